// File: rtl/bitpack_pkg.sv
// Shared AXI constants, FSM state types and burst sizing for the bitpack copy engine.
package bitpack_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;
  typedef enum logic [1:0] {JOB_IDLE, JOB_BUSY, JOB_DONE} job_state_t;

  // Words in the next burst: capped by what is left, the burst limit and the 4KB page end.
  function automatic logic [31:0] burst_words(input logic [9:0]  word_in_page,
                                              input logic [31:0] remaining,
                                              input logic [31:0] max_len);
    logic [31:0] to_4k;
    logic [31:0] len;
    to_4k = 32'd1024 - {22'd0, word_in_page};
    len   = remaining;
    if (max_len < len) len = max_len;
    if (to_4k < len)   len = to_4k;
    return len;
  endfunction

endpackage

// File: rtl/bitpack_sync_fifo.sv
// Single-clock 32-bit FIFO with first-word fall-through output and occupancy count.
module bitpack_sync_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [31:0]               din,
  input  logic                      pop,
  output logic [31:0]               dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bitpack_dma.sv
// Memory-to-memory copy engine: independent read and write burst FSMs joined by a data FIFO.
module bitpack_dma
  import bitpack_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        AXI_MEM_ACLK,
  input  logic        AXI_MEM_ARESET,
  input  logic [31:0] USER_SRC,
  input  logic [31:0] USER_DST,
  input  logic [31:0] USER_SIZE,
  input  logic        USER_GO,
  output logic        USER_DONE,
  output logic        USER_ERR,
  output logic [31:0] AXI_MEM_ARADDR,
  output logic [7:0]  AXI_MEM_ARLEN,
  output logic [2:0]  AXI_MEM_ARSIZE,
  output logic [1:0]  AXI_MEM_ARBURST,
  output logic        AXI_MEM_ARVALID,
  input  logic        AXI_MEM_ARREADY,
  input  logic [31:0] AXI_MEM_RDATA,
  input  logic [1:0]  AXI_MEM_RRESP,
  input  logic        AXI_MEM_RLAST,
  input  logic        AXI_MEM_RVALID,
  output logic        AXI_MEM_RREADY,
  output logic [31:0] AXI_MEM_AWADDR,
  output logic [7:0]  AXI_MEM_AWLEN,
  output logic [2:0]  AXI_MEM_AWSIZE,
  output logic [1:0]  AXI_MEM_AWBURST,
  output logic        AXI_MEM_AWVALID,
  input  logic        AXI_MEM_AWREADY,
  output logic [31:0] AXI_MEM_WDATA,
  output logic [3:0]  AXI_MEM_WSTRB,
  output logic        AXI_MEM_WLAST,
  output logic        AXI_MEM_WVALID,
  input  logic        AXI_MEM_WREADY,
  input  logic [1:0]  AXI_MEM_BRESP,
  input  logic        AXI_MEM_BVALID,
  output logic        AXI_MEM_BREADY
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  job_state_t  job_q, job_d;
  rd_state_t   rd_q, rd_d;
  wr_state_t   wr_q, wr_d;

  logic        go_q;
  logic        go_rise;
  logic [31:0] n_words;
  logic [31:0] rd_addr, wr_addr;
  logic [31:0] rd_rem, wr_rem;
  logic [7:0]  ar_len, aw_len, w_beat;
  logic        err_q;
  logic [31:0] rd_len, wr_len;
  logic [CW-1:0] fifo_count;
  logic [31:0] fifo_used, fifo_free;
  logic        fifo_empty;
  logic        r_fire, w_fire, b_fire;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{USER_SRC[1:0], USER_DST[1:0], USER_SIZE[1:0]};

  assign go_rise   = USER_GO && !go_q;
  assign n_words   = {2'b00, USER_SIZE[31:2]};
  assign rd_len    = burst_words(rd_addr[11:2], rd_rem, 32'(BURST_LEN));
  assign wr_len    = burst_words(wr_addr[11:2], wr_rem, 32'(BURST_LEN));
  assign fifo_used = 32'(fifo_count);
  assign fifo_free = 32'(FIFO_DEPTH) - fifo_used;

  assign r_fire = AXI_MEM_RVALID && AXI_MEM_RREADY;
  assign w_fire = AXI_MEM_WVALID && AXI_MEM_WREADY;
  assign b_fire = (wr_q == WR_B) && AXI_MEM_BVALID;

  assign AXI_MEM_ARADDR  = rd_addr;
  assign AXI_MEM_ARLEN   = ar_len;
  assign AXI_MEM_ARSIZE  = AXI_SIZE_4B;
  assign AXI_MEM_ARBURST = AXI_BURST_INCR;
  assign AXI_MEM_ARVALID = (rd_q == RD_AR);
  assign AXI_MEM_RREADY  = (rd_q == RD_R);
  assign AXI_MEM_AWADDR  = wr_addr;
  assign AXI_MEM_AWLEN   = aw_len;
  assign AXI_MEM_AWSIZE  = AXI_SIZE_4B;
  assign AXI_MEM_AWBURST = AXI_BURST_INCR;
  assign AXI_MEM_AWVALID = (wr_q == WR_AW);
  assign AXI_MEM_WSTRB   = 4'hF;
  assign AXI_MEM_WLAST   = (w_beat == aw_len);
  assign AXI_MEM_WVALID  = (wr_q == WR_W) && !fifo_empty;
  assign AXI_MEM_BREADY  = 1'b1;
  assign USER_DONE       = (job_q == JOB_DONE);
  assign USER_ERR        = err_q;

  bitpack_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (AXI_MEM_ACLK),
    .rst   (AXI_MEM_ARESET),
    .push  (r_fire),
    .din   (AXI_MEM_RDATA),
    .pop   (w_fire),
    .dout  (AXI_MEM_WDATA),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    job_d = job_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    case (job_q)
      JOB_IDLE: if (go_rise) job_d = (n_words == '0) ? JOB_DONE : JOB_BUSY;
      JOB_BUSY: if (b_fire && wr_rem == '0) job_d = JOB_DONE;
      JOB_DONE: if (!USER_GO) job_d = JOB_IDLE;
      default:  job_d = JOB_IDLE;
    endcase
    // Read side only reserves space it is sure of: the FIFO can only drain while a burst is in flight.
    case (rd_q)
      RD_IDLE: if (job_q == JOB_BUSY && rd_rem != '0 && fifo_free >= rd_len) rd_d = RD_AR;
      RD_AR:   if (AXI_MEM_ARREADY) rd_d = RD_R;
      RD_R:    if (r_fire && AXI_MEM_RLAST) rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
    case (wr_q)
      WR_IDLE: if (job_q == JOB_BUSY && wr_rem != '0 && fifo_used >= wr_len) wr_d = WR_AW;
      WR_AW:   if (AXI_MEM_AWREADY) wr_d = WR_W;
      WR_W:    if (w_fire && AXI_MEM_WLAST) wr_d = WR_B;
      WR_B:    if (AXI_MEM_BVALID) wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge AXI_MEM_ACLK) begin
    if (AXI_MEM_ARESET) begin
      job_q   <= JOB_IDLE;
      rd_q    <= RD_IDLE;
      wr_q    <= WR_IDLE;
      go_q    <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      rd_rem  <= '0;
      wr_rem  <= '0;
      ar_len  <= '0;
      aw_len  <= '0;
      w_beat  <= '0;
      err_q   <= 1'b0;
    end else begin
      job_q <= job_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      go_q  <= USER_GO;
      if (job_q == JOB_IDLE && go_rise) begin
        rd_addr <= {USER_SRC[31:2], 2'b00};
        wr_addr <= {USER_DST[31:2], 2'b00};
        rd_rem  <= n_words;
        wr_rem  <= n_words;
        err_q   <= 1'b0;
      end
      if (rd_q == RD_IDLE && rd_d == RD_AR) ar_len <= 8'(rd_len - 32'd1);
      if (wr_q == WR_IDLE && wr_d == WR_AW) aw_len <= 8'(wr_len - 32'd1);
      if (AXI_MEM_ARVALID && AXI_MEM_ARREADY) begin
        rd_addr <= rd_addr + ((32'(ar_len) + 32'd1) << 2);
        rd_rem  <= rd_rem - (32'(ar_len) + 32'd1);
      end
      if (AXI_MEM_AWVALID && AXI_MEM_AWREADY) begin
        wr_addr <= wr_addr + ((32'(aw_len) + 32'd1) << 2);
        wr_rem  <= wr_rem - (32'(aw_len) + 32'd1);
        w_beat  <= '0;
      end else if (w_fire) begin
        w_beat  <= w_beat + 8'd1;
      end
      if (r_fire && AXI_MEM_RRESP != RESP_OKAY) err_q <= 1'b1;
      if (b_fire && AXI_MEM_BRESP != RESP_OKAY) err_q <= 1'b1;
    end
  end

endmodule
